// File: rtl/immgen_pkg.sv
// immgen_pkg: shared definitions for the immediate/target generator.
//   - RISC-V base opcodes that the decoder recognises
//   - imm_fmt_t: 3-bit immediate format code
//   - entry_t: one decoded result {immediate, target, imm_fmt, illegal}.
//     The data fields are sized for the widest legal XLEN (64). Narrower
//     builds use only the low XLEN bits.
package immgen_pkg;

    localparam int XLEN_MAX = 64;

    localparam logic [6:0] OP_LOAD      = 7'b0000011;
    localparam logic [6:0] OP_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_AUIPC     = 7'b0010111;
    localparam logic [6:0] OP_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OP_STORE     = 7'b0100011;
    localparam logic [6:0] OP_LUI       = 7'b0110111;
    localparam logic [6:0] OP_BRANCH    = 7'b1100011;
    localparam logic [6:0] OP_JALR      = 7'b1100111;
    localparam logic [6:0] OP_JAL       = 7'b1101111;
    localparam logic [6:0] OP_SYSTEM    = 7'b1110011;

    typedef enum logic [2:0] {
        FMT_NONE  = 3'd0,
        FMT_I     = 3'd1,
        FMT_S     = 3'd2,
        FMT_B     = 3'd3,
        FMT_U     = 3'd4,
        FMT_J     = 3'd5,
        FMT_SHAMT = 3'd6,
        FMT_CSR   = 3'd7
    } imm_fmt_t;

    typedef struct packed {
        logic [XLEN_MAX-1:0] immediate;
        logic [XLEN_MAX-1:0] target;
        imm_fmt_t            imm_fmt;
        logic                illegal;
    } entry_t;

endpackage

// File: rtl/immgen_pipe_decode.sv
// imm_decode: purely combinational immediate decoder.
//   instruction [31:0]   in   raw instruction word
//   immediate [XLEN-1:0] out  sign-/zero-extended immediate (0 if no format)
//   imm_fmt [2:0]        out  format code (imm_fmt_t)
//   illegal              out  unrecognised encoding; driven only when
//                             IMMGEN_ILLEGAL_EN is defined, otherwise 0
// Parameter XLEN: 32 or 64. OP-IMM-32 is only recognised when XLEN=64.
module imm_decode
    import immgen_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instruction,
    output logic [XLEN-1:0] immediate,
    output logic [2:0]      imm_fmt,
    output logic            illegal
);

    logic [31:0] i;
    logic [2:0]  funct3;
    imm_fmt_t    fmt;

    assign i      = instruction;
    assign funct3 = instruction[14:12];

    always_comb begin
        immediate = '0;
        fmt       = FMT_NONE;
        case (i[6:0])
            OP_BRANCH: begin
                immediate = XLEN'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
                fmt       = FMT_B;
            end
            OP_JAL: begin
                immediate = XLEN'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0}));
                fmt       = FMT_J;
            end
            OP_LUI, OP_AUIPC: begin
                immediate = XLEN'($signed({i[31:12], 12'h000}));
                fmt       = FMT_U;
            end
            OP_LOAD, OP_JALR: begin
                immediate = XLEN'($signed(i[31:20]));
                fmt       = FMT_I;
            end
            OP_OP_IMM: begin
                // funct3 001/101 are SLLI/SRLI/SRAI; shamt grows to 6 bits on RV64
                if (funct3[1:0] == 2'b01) begin
                    if (XLEN == 64) immediate = XLEN'(i[25:20]);
                    else            immediate = XLEN'(i[24:20]);
                    fmt = FMT_SHAMT;
                end else begin
                    immediate = XLEN'($signed(i[31:20]));
                    fmt       = FMT_I;
                end
            end
            OP_OP_IMM_32: begin
                if (XLEN == 64) begin
                    if (funct3[1:0] == 2'b01) begin
                        immediate = XLEN'(i[24:20]);
                        fmt       = FMT_SHAMT;
                    end else begin
                        immediate = XLEN'($signed(i[31:20]));
                        fmt       = FMT_I;
                    end
                end
            end
            OP_SYSTEM: begin
                immediate = XLEN'(i[31:20]);
                fmt       = FMT_CSR;
            end
            OP_STORE: begin
                immediate = XLEN'($signed({i[31:25], i[11:7]}));
                fmt       = FMT_S;
            end
            default: ;
        endcase
    end

    assign imm_fmt = fmt;

`ifdef IMMGEN_ILLEGAL_EN
    assign illegal = (i[1:0] != 2'b11) || (fmt == FMT_NONE);
`else
    assign illegal = 1'b0;
`endif

endmodule

// File: rtl/immgen_pipe.sv
// immgen_pipe: decode-stage immediate and PC-relative target generator with
// an elastic output buffer (circular, BUF_DEPTH entries).
//   clk                   in   clock, rising edge
//   rst                   in   synchronous active-high reset
//   flush                 in   drop all buffered entries (push that cycle dropped)
//   in_valid / in_ready   in/out  input handshake; in_ready is registered state
//   instruction [31:0]    in   raw instruction
//   pc [XLEN-1:0]         in   instruction address
//   out_valid / out_ready out/in  output handshake
//   immediate [XLEN-1:0]  out  decoded immediate (0 when empty)
//   target [XLEN-1:0]     out  pc + immediate, modulo 2^XLEN (0 when empty)
//   imm_fmt [2:0]         out  format code (0 when empty)
//   illegal               out  unrecognised encoding (0 when empty)
// Build option: define IMMGEN_ILLEGAL_EN to decode and buffer the illegal
// flag; otherwise illegal is tied 0 and has no storage.
module immgen_pipe
    import immgen_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int BUF_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instruction,
    input  logic [XLEN-1:0] pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] immediate,
    output logic [XLEN-1:0] target,
    output logic [2:0]      imm_fmt,
    output logic            illegal
);

    localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CW = $clog2(BUF_DEPTH + 1);

    logic [XLEN-1:0] dec_imm;
    logic [2:0]      dec_fmt;
    logic            dec_ill;
    logic [XLEN-1:0] dec_tgt;
    entry_t          wr_entry;
    logic            unused_entry;

    logic [PW-1:0]   wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
    logic [CW-1:0]   count;
    logic            push, pop;

    logic [XLEN-1:0] imm_mem [BUF_DEPTH];
    logic [XLEN-1:0] tgt_mem [BUF_DEPTH];
    logic [2:0]      fmt_mem [BUF_DEPTH];
`ifdef IMMGEN_ILLEGAL_EN
    logic            ill_mem [BUF_DEPTH];
`endif

    imm_decode #(.XLEN(XLEN)) u_decode (
        .instruction (instruction),
        .immediate   (dec_imm),
        .imm_fmt     (dec_fmt),
        .illegal     (dec_ill)
    );

    // Adder sits in the input cycle so the buffer holds the finished target.
    assign dec_tgt = pc + dec_imm;

    always_comb begin
        wr_entry           = '0;
        wr_entry.immediate = XLEN_MAX'(dec_imm);
        wr_entry.target    = XLEN_MAX'(dec_tgt);
        wr_entry.imm_fmt   = imm_fmt_t'(dec_fmt);
        wr_entry.illegal   = dec_ill;
    end

    // Upper halves (XLEN=32) and the flag (option off) are intentionally dropped.
    assign unused_entry = ^wr_entry;

    assign in_ready  = (count != CW'(BUF_DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    assign wr_ptr_nxt = (wr_ptr == PW'(BUF_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
    assign rd_ptr_nxt = (rd_ptr == PW'(BUF_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr_nxt;
            if (pop)  rd_ptr <= rd_ptr_nxt;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // A write during flush/rst lands in a slot that is immediately abandoned.
    always_ff @(posedge clk) begin
        if (push) begin
            imm_mem[wr_ptr] <= wr_entry.immediate[XLEN-1:0];
            tgt_mem[wr_ptr] <= wr_entry.target[XLEN-1:0];
            fmt_mem[wr_ptr] <= wr_entry.imm_fmt;
`ifdef IMMGEN_ILLEGAL_EN
            ill_mem[wr_ptr] <= wr_entry.illegal;
`endif
        end
    end

    always_comb begin
        immediate = '0;
        target    = '0;
        imm_fmt   = '0;
        illegal   = 1'b0;
        if (out_valid) begin
            immediate = imm_mem[rd_ptr];
            target    = tgt_mem[rd_ptr];
            imm_fmt   = fmt_mem[rd_ptr];
`ifdef IMMGEN_ILLEGAL_EN
            illegal   = ill_mem[rd_ptr];
`endif
        end
    end

endmodule

// File: tb/tb_immgen_pipe.sv
// Scoreboard bench for immgen_pipe: one XLEN=32 instance with full handshake,
// backpressure, flush and reset scenarios, plus an XLEN=64 instance fed a
// stream of RV64-specific vectors. Expected entries are queued at accept
// time; monitors pop and compare whenever a DUT hands out an entry.
module tb_immgen_pipe;
    import immgen_pkg::*;

    typedef struct {
        logic [63:0] imm;
        logic [63:0] tgt;
        logic [2:0]  fmt;
        logic        ill;
    } exp_t;

`ifdef IMMGEN_ILLEGAL_EN
    localparam logic ILL_EN = 1'b1;
`else
    localparam logic ILL_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, flush;
    logic        in_valid, in_ready, out_valid, out_ready, illegal;
    logic [31:0] instruction, pc, immediate, target;
    logic [2:0]  imm_fmt;

    logic        flush_w, in_valid_w, in_ready_w, out_valid_w, out_ready_w, illegal_w;
    logic [31:0] instruction_w;
    logic [63:0] pc_w, immediate_w, target_w;
    logic [2:0]  imm_fmt_w;

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t sb32[$];
    exp_t sb64[$];
    logic go64 = 1'b0;
    logic done64 = 1'b0;

    immgen_pipe #(.XLEN(32), .BUF_DEPTH(2)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .instruction(instruction), .pc(pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .immediate(immediate), .target(target),
        .imm_fmt(imm_fmt), .illegal(illegal)
    );

    immgen_pipe #(.XLEN(64), .BUF_DEPTH(2)) dut64 (
        .clk(clk), .rst(rst), .flush(flush_w),
        .in_valid(in_valid_w), .in_ready(in_ready_w),
        .instruction(instruction_w), .pc(pc_w),
        .out_valid(out_valid_w), .out_ready(out_ready_w),
        .immediate(immediate_w), .target(target_w),
        .imm_fmt(imm_fmt_w), .illegal(illegal_w)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic note_fail(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: got timeout/unexpected expected event", name);
    endtask

    always @(negedge clk) begin : mon32
        exp_t e;
        if (!rst && !flush && out_valid && out_ready) begin
            if (sb32.size() == 0) note_fail("mon32_unexpected_output");
            else begin
                e = sb32.pop_front();
                check("imm32", {32'h0, immediate}, {32'h0, e.imm[31:0]});
                check("tgt32", {32'h0, target},    {32'h0, e.tgt[31:0]});
                check("fmt32", 64'(imm_fmt), 64'(e.fmt));
                check("ill32", 64'(illegal), 64'(e.ill));
            end
        end
    end

    always @(negedge clk) begin : mon64
        exp_t e;
        if (!rst && out_valid_w && out_ready_w) begin
            if (sb64.size() == 0) note_fail("mon64_unexpected_output");
            else begin
                e = sb64.pop_front();
                check("imm64", immediate_w, e.imm);
                check("tgt64", target_w,    e.tgt);
                check("fmt64", 64'(imm_fmt_w), 64'(e.fmt));
                check("ill64", 64'(illegal_w), 64'(e.ill));
            end
        end
    end

    // Present one word, wait (bounded) for acceptance, queue its expectation.
    task automatic send32(input logic [31:0] ins, input logic [31:0] p,
                          input logic [31:0] e_imm, input logic [31:0] e_tgt,
                          input logic [2:0] e_fmt, input logic e_ill);
        exp_t e;
        int   waited = 0;
        instruction = ins;
        pc          = p;
        in_valid    = 1'b1;
        @(negedge clk);
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            note_fail("send32_accept");
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            e.imm = {32'h0, e_imm};
            e.tgt = {32'h0, e_tgt};
            e.fmt = e_fmt;
            e.ill = e_ill;
            sb32.push_back(e);
            #1;
        end
    endtask

    task automatic send64(input logic [31:0] ins, input logic [63:0] p,
                          input logic [63:0] e_imm, input logic [63:0] e_tgt,
                          input logic [2:0] e_fmt);
        exp_t e;
        int   waited = 0;
        instruction_w = ins;
        pc_w          = p;
        in_valid_w    = 1'b1;
        @(negedge clk);
        while (!in_ready_w && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready_w) begin
            note_fail("send64_accept");
            in_valid_w = 1'b0;
        end else begin
            @(posedge clk);
            e.imm = e_imm;
            e.tgt = e_tgt;
            e.fmt = e_fmt;
            e.ill = 1'b0;
            sb64.push_back(e);
            #1;
        end
    endtask

    task automatic drain32();
        int n = 0;
        while (sb32.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        if (sb32.size() != 0) note_fail("drain32");
        #1;
    endtask

    initial begin : stim64
        int n = 0;
        flush_w = 1'b0; in_valid_w = 1'b0; out_ready_w = 1'b1;
        instruction_w = '0; pc_w = '0;
        wait (go64);
        @(posedge clk); #1;
        send64(32'h800000B7, 64'h0,   64'hFFFFFFFF80000000, 64'hFFFFFFFF80000000, FMT_U);
        send64(32'h02109093, 64'h10,  64'd33, 64'h31, FMT_SHAMT);
        send64(32'hFFF0809B, 64'h8,   64'hFFFFFFFFFFFFFFFF, 64'h7, FMT_I);
        send64(32'h03F0909B, 64'h0,   64'd31, 64'd31, FMT_SHAMT);
        send64(32'hFE000EE3, 64'h100, 64'hFFFFFFFFFFFFFFFC, 64'hFC, FMT_B);
        send64(32'hFF808067, 64'h0,   64'hFFFFFFFFFFFFFFF8, 64'hFFFFFFFFFFFFFFF8, FMT_I);
        in_valid_w = 1'b0;
        while (sb64.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        if (sb64.size() != 0) note_fail("drain64");
        done64 = 1'b1;
    end

    initial begin : stim32
        int n = 0;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        instruction = '0; pc = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready",  64'(in_ready),  64'd1);
        check("rst_immediate", 64'(immediate), 64'd0);
        check("rst_target",    64'(target),    64'd0);
        check("rst_imm_fmt",   64'(imm_fmt),   64'd0);
        check("rst_illegal",   64'(illegal),   64'd0);
        go64 = 1'b1;

        // Streaming with out_ready high
        out_ready = 1'b1;
        send32(32'hFE000EE3, 32'h100, 32'hFFFFFFFC, 32'h000000FC, FMT_B, 1'b0);
        check("latency_out_valid", 64'(out_valid), 64'd1);
        send32(32'h0040006F, 32'h200, 32'h4, 32'h204, FMT_J, 1'b0);
        send32(32'h800000B7, 32'h300, 32'h80000000, 32'h80000300, FMT_U, 1'b0);
        send32(32'hFFF00093, 32'h10, 32'hFFFFFFFF, 32'hF, FMT_I, 1'b0);
        send32(32'h0020A423, 32'h20, 32'h8, 32'h28, FMT_S, 1'b0);
        send32(32'hC00020F3, 32'h0, 32'hC00, 32'hC00, FMT_CSR, 1'b0);
        send32(32'h4030D093, 32'h0, 32'h3, 32'h3, FMT_SHAMT, 1'b0);
        send32(32'h00000000, 32'h40, 32'h0, 32'h40, FMT_NONE, ILL_EN);
        send32(32'h00001097, 32'h100, 32'h1000, 32'h1100, FMT_U, 1'b0);
        send32(32'hFF808067, 32'h1000, 32'hFFFFFFF8, 32'hFF8, FMT_I, 1'b0);
        send32(32'h002080B3, 32'h0, 32'h0, 32'h0, FMT_NONE, ILL_EN);
        send32(32'hFFF03093, 32'h4, 32'hFFFFFFFF, 32'h3, FMT_I, 1'b0);
        send32(32'h0040006F, 32'hFFFFFFFC, 32'h4, 32'h0, FMT_J, 1'b0);
        in_valid = 1'b0;
        drain32();

        // Backpressure: two fill the buffer, the third is held
        out_ready = 1'b0;
        send32(32'hFFF00093, 32'h10, 32'hFFFFFFFF, 32'hF, FMT_I, 1'b0);
        send32(32'h0020A423, 32'h20, 32'h8, 32'h28, FMT_S, 1'b0);
        check("full_in_ready",  64'(in_ready),  64'd0);
        check("full_out_valid", 64'(out_valid), 64'd1);
        instruction = 32'h0040006F;
        pc          = 32'h200;
        in_valid    = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("held_in_ready", 64'(in_ready),  64'd0);
            check("hold_immediate", 64'(immediate), 64'hFFFFFFFF);
            check("hold_target",    64'(target),    64'hF);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        send32(32'h0040006F, 32'h200, 32'h4, 32'h204, FMT_J, 1'b0);
        in_valid = 1'b0;
        drain32();

        // Flush while full with a push offered
        out_ready = 1'b0;
        send32(32'hFE000EE3, 32'h100, 32'hFFFFFFFC, 32'hFC, FMT_B, 1'b0);
        send32(32'h00001097, 32'h100, 32'h1000, 32'h1100, FMT_U, 1'b0);
        instruction = 32'h0040006F; pc = 32'h200; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        sb32.delete();
        check("flush_full_out_valid", 64'(out_valid), 64'd0);
        check("flush_full_in_ready",  64'(in_ready),  64'd1);

        // Flush with one entry and an acceptable push: the push is dropped
        send32(32'hFE000EE3, 32'h100, 32'hFFFFFFFC, 32'hFC, FMT_B, 1'b0);
        instruction = 32'h0040006F; pc = 32'h200; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        sb32.delete();
        repeat (2) begin
            @(negedge clk);
            check("flush_push_dropped", 64'(out_valid), 64'd0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        send32(32'hC00020F3, 32'h0, 32'hC00, 32'hC00, FMT_CSR, 1'b0);
        in_valid = 1'b0;
        drain32();

        // Reset mid-transfer, once the 64-bit stream has finished
        while (!done64 && n < 500) begin
            @(posedge clk);
            n++;
        end
        if (!done64) note_fail("done64_wait");
        #1;
        out_ready = 1'b0;
        send32(32'hFFF00093, 32'h10, 32'hFFFFFFFF, 32'hF, FMT_I, 1'b0);
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sb32.delete();
        check("rst_mid_out_valid", 64'(out_valid), 64'd0);
        check("rst_mid_in_ready",  64'(in_ready),  64'd1);
        check("rst_mid_immediate", 64'(immediate), 64'd0);

        check("sb32_empty", 64'(sb32.size()), 64'd0);
        check("sb64_empty", 64'(sb64.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/immgen_pipe.md
# immgen_pipe

Pipelined, XLEN-parametrised immediate and target generator for the decode stage. It accepts one 32-bit instruction plus its PC per valid/ready handshake and decodes the instruction-format immediate, sign- or zero-extended to XLEN. It also computes the PC-relative target for branch, JAL and AUIPC. Results are queued in a small elastic output buffer so the fetch and execute handshakes are decoupled with no combinational ready path.

## Interface
Parameters:
- XLEN, 32: datapath width; legal values are 32 and 64.
- BUF_DEPTH, 2: output buffer entries; must be a power of two, ≥1.

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- flush  in  1  discards all buffered entries
- in_valid  in  1  instruction/PC presented
- in_ready  out  1  buffer can accept
- instruction  in  32  raw instruction word
- pc  in  XLEN  instruction address
- out_valid  out  1  head entry valid
- out_ready  in  1  consumer accepts head
- immediate  out  XLEN  decoded immediate
- target  out  XLEN  pc + immediate (modulo 2^XLEN)
- imm_fmt  out  3  format code: NONE, I, S, B, U, J, SHAMT, CSR
- illegal  out  1  unrecognised encoding (see Configuration)

## Operation
- Decode by opcode instruction[6:0]; funct3 is instruction[14:12].
- B (1100011): sign-extended {i[31],i[7],i[30:25],i[11:8],0}.
- J (1101111): sign-extended {i[31],i[19:12],i[20],i[30:21],0}.
- U (0110111 LUI, 0010111 AUIPC): {i[31:12],12'h0}, sign-extended to XLEN.
- I (0000011 load, 1100111 JALR, 0010011 OP-IMM): sign-extended i[31:20]. SLTIU is also sign-extended.
- SHAMT (OP-IMM funct3 001/101): zero-extended shamt. Shamt is i[24:20] when XLEN=32 and i[25:20] when XLEN=64.
- When XLEN=64, OP-IMM-32 (0011011) is also decoded: shifts use i[24:20]; all other funct3 use the I rule.
- CSR (1110011): zero-extended i[31:20].
- S (0100011): sign-extended {i[31:25],i[11:7]}.
- Any other opcode: immediate 0, imm_fmt NONE.
- target is pc+immediate for every entry; the consumer ignores it when it is not meaningful.
- Push: in_valid && in_ready writes the decoded entry at the tail.
- Pop: out_valid && out_ready advances the head.
- in_ready = (count != BUF_DEPTH). It is registered state only and never depends on out_ready.
- Push and pop in the same cycle leave count unchanged. This is legal at any count below BUF_DEPTH.
- Flush clears count and both pointers. A push in the same cycle as flush is dropped, and a pop in that cycle is ignored.
- Pointers wrap modulo BUF_DEPTH.

## Timing
- Latency: an instruction accepted at edge N is presented with out_valid=1 after edge N (registered entry, readable in cycle N+1).
- Throughput: one result per cycle when out_ready is held high.
- The decode and the target adder sit in the input cycle, in front of the buffer write.
- Reset (synchronous): count=0, pointers=0, out_valid=0, in_ready=1. immediate, target, imm_fmt and illegal read 0 while empty.
- rst mid-transfer behaves like flush; rst has priority over flush.
- After flush or rst, out_valid=0 in the next cycle and in_ready=1.
- Outputs stay stable while out_valid=1 and out_ready=0.

## Configuration
- Macro IMMGEN_ILLEGAL_EN.
- When defined, illegal=1 if instruction[1:0] != 2'b11 or the opcode is not in the decoded set. The flag is buffered alongside the entry.
- When undefined, the illegal port is still present, tied 0, and no flag storage is built.

## Structure
- Package immgen_pkg holds:
  - the opcode localparams;
  - imm_fmt_t, a 3-bit enum;
  - the entry struct {immediate, target, imm_fmt, illegal}.
- Sub-module imm_decode is the purely combinational decode (instruction → immediate, imm_fmt, illegal), parametrised by XLEN.
- immgen_pipe instantiates imm_decode and adds the adder, the circular buffer and the handshake logic.

## Test plan
- XLEN=32, pc=0x100, instruction 0xFE000EE3 (beq x0,x0,-4) → immediate 0xFFFFFFFC, target 0x000000FC, imm_fmt B, out_valid one cycle after accept.
- pc=0x200, 0x0040006F (jal x0,4) → immediate 0x4, target 0x204, imm_fmt J.
- XLEN=64, 0x800000B7 (lui x1,0x80000) → 0xFFFFFFFF80000000. Also 0x02109093 (slli x1,x1,33) → immediate 33, imm_fmt SHAMT.
- BUF_DEPTH=2, out_ready=0, three back-to-back pushes → in_ready falls after the second accept and the third is held. Then out_ready=1 → all three are delivered in order.
- Buffer full, flush together with in_valid → next cycle out_valid=0, in_ready=1, and the pushed word is absent.
- Instruction 0x00000000 → illegal=1 with IMMGEN_ILLEGAL_EN defined, illegal=0 without; immediate=0 and imm_fmt NONE in both builds.
